// File: rtl/conv_pkg.sv
// Shared definitions for the KxK shift-weight convolution kernel:
// FSM states, weight-word field positions and accumulator sizing.
package conv_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Weight word layout is {zero, sign, shift[SW-1:0]}.
  function automatic int w_zero_bit(input int sw);
    return sw + 1;
  endfunction

  function automatic int w_sign_bit(input int sw);
    return sw;
  endfunction

  // Widest product is DW+2^SW-1 magnitude bits; K*K of them plus a sign bit.
  function automatic int acc_width(input int dw, input int sw, input int k);
    return dw + (1 << sw) + $clog2(k * k) + 1;
  endfunction

endpackage

// File: rtl/shift_weight_mul.sv
// Pixel times power-of-two weight: zero-extend, shift, optional two's-complement
// negate. Purely combinational.
module shift_weight_mul
  import conv_pkg::*;
#(
  parameter int DW = 8,
  parameter int SW = 3,
  parameter int WB = SW + 2,
  parameter int AW = acc_width(DW, SW, 3)
) (
  input  logic [DW-1:0]        pix_i,
  input  logic [WB-1:0]        w_i,
  output logic signed [AW-1:0] prod_o
);

  localparam int ZB = w_zero_bit(SW);
  localparam int SB = w_sign_bit(SW);

  logic [AW-1:0] mag;

  always_comb begin
    mag = {{(AW-DW){1'b0}}, pix_i} << w_i[SW-1:0];
    if (w_i[ZB]) begin
      prod_o = '0;
    end else if (w_i[SB]) begin
      prod_o = $signed(~mag + AW'(1));
    end else begin
      prod_o = $signed(mag);
    end
  end

endmodule

// File: rtl/conv_kernel_kxk.sv
// KxK power-of-two-weight convolution: weight-load FSM, K-deep column window,
// registered products (stage 1) and registered adder-tree sum (stage 2).
module conv_kernel_kxk
  import conv_pkg::*;
#(
  parameter  int K  = 3,
  parameter  int DW = 8,
  parameter  int SW = 3,
  parameter  int WB = SW + 2,
  localparam int AW = acc_width(DW, SW, K)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_start,
  input  logic                 w_valid,
  input  logic [WB-1:0]        w_data,
  output logic                 w_done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K*DW-1:0]      in_pix,
  input  logic                 in_sol,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_y
);

  localparam int NW = K * K;
  localparam int IW = $clog2(NW + 1);
  localparam int FW = $clog2(K + 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 w_we;
  logic [WB-1:0]        wt_q [NW];
  logic [K*DW-1:0]      win_q [K];
  logic [FW-1:0]        fill_q, fill_d;
  logic                 pend_q, pend_d;
  logic                 s1_valid_q;
  logic signed [AW-1:0] prod_q [NW];
  logic signed [AW-1:0] prod_c [NW];
  logic signed [AW-1:0] sum_c;
  logic                 out_valid_q;
  logic signed [AW-1:0] out_y_q;
  logic                 advance, accept, out_load;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_we    = 1'b0;
    if (w_start) begin
      state_d = LOAD;
      idx_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (w_valid) begin
            w_we  = 1'b1;
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(NW - 1)) begin
              state_d = RUN;
            end
          end
        end
        RUN:     state_d = RUN;
        default: state_d = LOAD;
      endcase
    end
  end

  // pend_q marks that win_q holds a qualifying window not yet taken by
  // stage 1; window, stage 1 and stage 2 stall together on backpressure.
  assign advance  = !s1_valid_q || !out_valid_q || out_ready;
  assign in_ready = (state_q == RUN) && advance;
  assign accept   = in_valid && in_ready && !w_start;
  assign out_load = !out_valid_q || out_ready;
  assign w_done   = (state_q == RUN);

  always_comb begin
    if (in_sol) begin
      fill_d = FW'(1);
    end else if (fill_q >= FW'(K)) begin
      fill_d = FW'(K);
    end else begin
      fill_d = fill_q + FW'(1);
    end
    pend_d = accept && (fill_d >= FW'(K));
  end

  // weight[r*K+c] pairs with row r of window slot K-1-c (slot 0 is newest).
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      shift_weight_mul #(
        .DW(DW),
        .SW(SW),
        .WB(WB),
        .AW(AW)
      ) u_mul (
        .pix_i  (win_q[K-1-c][r*DW +: DW]),
        .w_i    (wt_q[r*K+c]),
        .prod_o (prod_c[r*K+c])
      );
    end
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      sum_c = sum_c + prod_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      fill_q      <= '0;
      pend_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      for (int unsigned i = 0; i < NW; i++) begin
        wt_q[i]   <= {1'b1, {(WB-1){1'b0}}};
        prod_q[i] <= '0;
      end
      for (int unsigned i = 0; i < K; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int unsigned i = 0; i < NW; i++) begin
        if (w_we && (idx_q == IW'(i))) begin
          wt_q[i] <= w_data;
        end
      end
      if (w_start) begin
        fill_q      <= '0;
        pend_q      <= 1'b0;
        s1_valid_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        if (accept) begin
          win_q[0] <= in_pix;
          for (int unsigned i = 1; i < K; i++) begin
            win_q[i] <= win_q[i-1];
          end
          fill_q <= fill_d;
        end
        if (advance) begin
          pend_q     <= pend_d;
          s1_valid_q <= pend_q;
          if (pend_q) begin
            prod_q <= prod_c;
          end
        end
        if (out_load) begin
          out_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            out_y_q <= sum_c;
          end
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_conv_kernel_kxk.sv
// Directed and randomized bench for conv_kernel_kxk against a line-history
// reference model and result scoreboard.
module tb_conv_kernel_kxk;
  import conv_pkg::*;

  localparam int K  = 3;
  localparam int DW = 8;
  localparam int SW = 3;
  localparam int WB = SW + 2;
  localparam int NW = K * K;
  localparam int AW = acc_width(DW, SW, K);

  logic                 clk = 1'b0;
  logic                 rst, w_start, w_valid, w_done;
  logic [WB-1:0]        w_data;
  logic                 in_valid, in_ready, in_sol;
  logic [K*DW-1:0]      in_pix;
  logic                 out_valid, out_ready;
  logic signed [AW-1:0] out_y;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;

  typedef struct {
    longint val;
    int     edge_n;
  } exp_t;

  exp_t                 exp_q[$];
  logic [K*DW-1:0]      line_q[$];
  logic [WB-1:0]        wt_m [NW];
  bit                   chk_lat = 1'b0;
  bit                   held    = 1'b0;
  logic signed [AW-1:0] held_y;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  conv_kernel_kxk #(
    .K (K),
    .DW(DW),
    .SW(SW),
    .WB(WB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .w_start  (w_start),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .w_done   (w_done),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pix   (in_pix),
    .in_sol   (in_sol),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
    end
  endtask

  function automatic longint wval(input logic [WB-1:0] w, input int p);
    longint v;
    if (w[WB-1]) return 0;
    v = longint'(p) << w[SW-1:0];
    return w[SW] ? -v : v;
  endfunction

  // Sum over the last K columns of the current line (line_q[0] is newest).
  function automatic longint window_sum();
    longint          s = 0;
    logic [K*DW-1:0] col;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        col = line_q[K-1-c];
        s += wval(wt_m[r*K+c], int'(col[r*DW +: DW]));
      end
    end
    return s;
  endfunction

  task automatic model_accept(input logic [K*DW-1:0] pix, input logic sol,
                              input int edge_n);
    exp_t e;
    if (sol) line_q.delete();
    line_q.push_front(pix);
    if (line_q.size() > K) void'(line_q.pop_back());
    if (line_q.size() == K) begin
      e.val    = window_sum();
      e.edge_n = edge_n;
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [K*DW-1:0] flat_col(input logic [DW-1:0] v);
    return {K{v}};
  endfunction

  // One clock: drive at negedge, sample at negedge+1, update model at posedge.
  task automatic step(input logic iv, input logic [K*DW-1:0] pix, input logic sol,
                      input logic ordy, output logic ir, output logic ov);
    exp_t e;
    bit   acc;
    int   acc_edge;
    in_valid  = iv;
    in_pix    = pix;
    in_sol    = sol;
    out_ready = ordy;
    #1;
    ir = in_ready;
    ov = out_valid;
    if (held && out_valid) chk("hold_stable", out_y, held_y);
    if (exp_q.size() == 0) begin
      chk("no_result_expected", out_valid, 0);
    end else if (out_valid && ordy) begin
      e = exp_q.pop_front();
      chk("out_y", out_y, e.val);
      if (chk_lat) chk("latency", edges - e.edge_n, 2);
    end
    held     = out_valid && !ordy;
    held_y   = out_y;
    acc      = iv && in_ready;
    acc_edge = edges + 1;
    @(posedge clk);
    if (acc) model_accept(pix, sol, acc_edge);
    @(negedge clk);
  endtask

  task automatic go(input logic iv, input logic [K*DW-1:0] pix, input logic sol,
                    input logic ordy);
    logic ir, ov;
    step(iv, pix, sol, ordy, ir, ov);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) go(1'b0, '0, 1'b0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic load(input logic [WB-1:0] ws [NW]);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NW; i++) begin
      w_valid = 1'b1;
      w_data  = ws[i];
      #1;
      chk("load_in_ready", in_ready, 0);
      chk("load_w_done", w_done, 0);
      wt_m[i] = ws[i];
      @(negedge clk);
    end
    w_valid = 1'b0;
    #1;
    chk("armed_w_done", w_done, 1);
    chk("armed_in_ready", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    w_start   = 1'b1;
    @(posedge clk);
    #1;
    w_start = 1'b0;
    chk("wstart_out_valid", out_valid, 0);
    chk("wstart_w_done", w_done, 0);
    chk("wstart_in_ready", in_ready, 0);
    exp_q.delete();
    line_q.delete();
    held = 1'b0;
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_w_done", w_done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_y", out_y, 0);
    exp_q.delete();
    line_q.delete();
    held = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WB-1:0]   ws [NW];
    logic            ir, ov;
    logic [K*DW-1:0] rp;

    rst = 1'b1; w_start = 1'b0; w_valid = 1'b0; w_data = '0;
    in_valid = 1'b0; in_pix = '0; in_sol = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_w_done", w_done, 0);
    chk("reset_out_y", out_y, 0);
    rst = 1'b0;
    @(negedge clk);

    // All +1 weights, unit pixels: 9 from the third column on.
    foreach (ws[i]) ws[i] = 5'b00000;
    load(ws);
    chk_lat = 1'b1;
    for (int i = 0; i < 6; i++) go(1'b1, flat_col(8'd1), i == 0, 1'b1);
    drain();

    // Centre +8, top-left -1; then a zero centre pixel.
    pulse_start();
    foreach (ws[i]) ws[i] = 5'b10000;
    ws[4] = 5'b00011;
    ws[0] = 5'b01000;
    load(ws);
    for (int i = 0; i < 4; i++) go(1'b1, flat_col(8'd255), i == 0, 1'b1);
    go(1'b1, 24'hFF00FF, 1'b0, 1'b1);
    go(1'b1, flat_col(8'd255), 1'b0, 1'b1);
    drain();

    // Most negative window: every weight -128, every pixel 255.
    pulse_start();
    foreach (ws[i]) ws[i] = 5'b01111;
    load(ws);
    for (int i = 0; i < 4; i++) go(1'b1, flat_col(8'd255), i == 0, 1'b1);
    drain();

    // Backpressure with full input, then release.
    pulse_start();
    foreach (ws[i]) ws[i] = WB'($urandom_range(0, 31));
    load(ws);
    chk_lat = 1'b0;
    for (int i = 0; i < 6; i++) go(1'b1, (K*DW)'($urandom), i == 0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, (K*DW)'($urandom), 1'b0, 1'b0, ir, ov);
    chk("stall_in_ready", ir, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (K*DW)'($urandom), 1'b0, 1'b1, ir, ov);
      chk("burst_out_valid", ov, 1);
    end
    drain();

    // Start of line mid-stream.
    chk_lat = 1'b1;
    for (int i = 0; i < 9; i++) go(1'b1, (K*DW)'($urandom), (i == 0) || (i == 4), 1'b1);
    drain();

    // Random traffic with random weights, lines and backpressure.
    pulse_start();
    foreach (ws[i]) ws[i] = WB'($urandom_range(0, 31));
    load(ws);
    chk_lat = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rp = (K*DW)'($urandom);
      go($urandom_range(0, 3) != 0, rp, $urandom_range(0, 15) == 0,
         $urandom_range(0, 3) != 0);
    end
    drain();

    // w_start with results pending, then async reset mid-load.
    for (int i = 0; i < 4; i++) go(1'b1, (K*DW)'($urandom), i == 0, 1'b0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1;
      w_data  = WB'($urandom_range(0, 31));
      @(negedge clk);
    end
    w_valid = 1'b0;
    async_reset();
    foreach (ws[i]) ws[i] = WB'($urandom_range(0, 31));
    load(ws);
    for (int i = 0; i < 5; i++) go(1'b1, (K*DW)'($urandom), i == 0, 1'b0);
    chk("pending_before_rst", out_valid, 1);
    async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
